// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender followed by a two-entry skid buffer
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_extop,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);
   logic [OUT_W-1:0] zx, sx, ext, skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_v, acc, load;
   assign zx       = {{(OUT_W-IN_W){1'b0}}, in_imm};
   assign sx       = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
   assign in_ready = ~skid_v;
   assign acc      = in_valid & in_ready & ~flush;
   assign load     = ~out_valid | out_ready;
   // extend on the input side so only the final result is ever stored
   always_comb begin
      ext = in_extop == 2'd0 ? zx :
            in_extop == 2'd1 ? sx :
            in_extop == 2'd2 ? {in_imm, {(OUT_W-IN_W){1'b0}}} :
                               {sx[OUT_W-3:0], 2'b00};
   end
   // valid bits: reset beats flush, flush beats every handshake
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         out_valid <= 1'b0;
         skid_v    <= 1'b0;
      end else begin
         if (load) out_valid <= skid_v | acc;
         skid_v <= load ? (skid_v & acc) : (skid_v | acc);
      end
   end
   // data registers are don't-care while their valid bit is low
   always_ff @(posedge clk) begin
      if (load) begin
         out_imm <= skid_v ? skid_imm : ext;
         out_tag <= skid_v ? skid_tag : in_tag;
      end
      if (acc && (!load || skid_v)) begin
         skid_imm <= ext;
         skid_tag <= in_tag;
      end
   end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed and randomized checks of the extender pipeline
module tb_imm_ext_pipe;
   logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic        in_ready, out_valid;
   logic [15:0] in_imm = 0;
   logic [1:0]  in_extop = 0;
   logic [4:0]  in_tag = 0, out_tag;
   logic [31:0] out_imm;
   logic        p_in_valid = 0, p_in_ready, p_out_valid;
   logic [7:0]  p_in_imm = 0;
   logic [1:0]  p_in_extop = 0;
   logic [4:0]  p_in_tag = 0, p_out_tag;
   logic [15:0] p_out_imm;
   int          n_chk = 0, n_fail = 0;

   imm_ext_pipe dut (.clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_extop(in_extop), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_tag(out_tag));

   imm_ext_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (.clk(clk), .reset(reset), .flush(flush),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm), .in_extop(p_in_extop), .in_tag(p_in_tag),
      .out_valid(p_out_valid), .out_ready(out_ready), .out_imm(p_out_imm), .out_tag(p_out_tag));

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic longint ext_ref(longint imm, int op, int iw, int ow);
      longint one = 1;
      longint s = imm >= (one << (iw - 1)) ? imm - (one << iw) : imm;
      longint r = op == 0 ? imm : op == 1 ? s : op == 2 ? imm * (one << (ow - iw)) : s * 4;
      return r & ((one << ow) - 1);
   endfunction

   task automatic test_reset();
      reset = 1; cyc(); cyc();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      reset = 0;
   endtask

   task automatic test_modes();
      logic [15:0] imms [5] = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF};
      logic [1:0]  ops  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      logic [31:0] exps [5] = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010, 32'h00007FFF};
      out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_imm = imms[i]; in_extop = ops[i]; in_tag = 5'(i + 10);
         cyc();
         n_chk++; if (out_valid !== 1'b1 || out_imm !== exps[i] || out_tag !== 5'(i + 10)) begin
            n_fail++; $display("FAIL mode%0d got v=%b imm=%h tag=%0d want v=1 imm=%h tag=%0d", i, out_valid, out_imm, out_tag, exps[i], i + 10);
         end
      end
      in_valid = 0; cyc();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL modes_drain got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 0; in_valid = 1; in_extop = 0; in_imm = 16'h0001; in_tag = 1; cyc();
      in_tag = 2; cyc();
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got in_ready=%b want 0", in_ready); end
      in_tag = 3; cyc(); cyc();
      n_chk++; if (in_ready !== 1'b0 || out_tag !== 5'd1) begin n_fail++; $display("FAIL bp_hold got in_ready=%b tag=%0d want 0 1", in_ready, out_tag); end
      out_ready = 1; cyc();
      n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd2) begin n_fail++; $display("FAIL bp_second got v=%b tag=%0d want 1 2", out_valid, out_tag); end
      cyc();
      n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd3) begin n_fail++; $display("FAIL bp_third got v=%b tag=%0d want 1 3", out_valid, out_tag); end
      in_valid = 0; cyc();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 0; in_valid = 1; in_tag = 4; cyc();
      in_tag = 5; cyc();
      in_tag = 6; flush = 1; cyc();
      flush = 0; in_valid = 0;
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush got v=%b rdy=%b want 0 1", out_valid, in_ready); end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost got v=%b tag=%0d want 0", out_valid, out_tag); end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 0; in_valid = 1; in_tag = 7; cyc(); in_tag = 8; cyc();
      in_valid = 0; reset = 1; cyc();
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid got v=%b rdy=%b want 0 1", out_valid, in_ready); end
      reset = 0; in_valid = 1; in_imm = 16'h0001; in_extop = 1; in_tag = 9; cyc();
      in_valid = 0;
      n_chk++; if (out_valid !== 1'b1 || out_imm !== 32'h00000001 || out_tag !== 5'd9) begin
         n_fail++; $display("FAIL rst_first got v=%b imm=%h tag=%0d want 1 00000001 9", out_valid, out_imm, out_tag);
      end
      out_ready = 1; cyc();
   endtask

   task automatic test_param();
      logic [15:0] exps [3] = '{16'hFF80, 16'h8000, 16'hFE00};
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         p_in_valid = 1; p_in_imm = 8'h80; p_in_extop = 2'(i + 1); p_in_tag = 5'(i); cyc();
         n_chk++; if (p_out_valid !== 1'b1 || p_out_imm !== exps[i]) begin
            n_fail++; $display("FAIL param_op%0d got v=%b imm=%h want 1 %h", i + 1, p_out_valid, p_out_imm, exps[i]);
         end
      end
      p_in_valid = 0; cyc();
   endtask

   task automatic test_random();
      longint q_imm [$];
      int     q_tag [$];
      int     beats = 0, cycles = 0;
      bit     has, acc;
      reset = 1; in_valid = 0; cyc(); reset = 0;
      while (beats < 10000 && cycles < 40000) begin
         in_valid = $urandom_range(0, 9) < 7; out_ready = $urandom_range(0, 9) < 7;
         flush = $urandom_range(0, 199) == 0;
         in_imm = 16'($urandom); in_extop = 2'($urandom_range(0, 3)); in_tag = 5'($urandom);
         has = q_imm.size() > 0; acc = in_valid && q_imm.size() < 2;
         n_chk++; if (out_valid !== has) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cycles, out_valid, has); end
         n_chk++; if (in_ready !== (q_imm.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cycles, in_ready, q_imm.size() < 2); end
         if (flush) begin
            q_imm.delete(); q_tag.delete();
         end else begin
            if (has && out_ready) begin
               n_chk++; if (longint'(out_imm) !== q_imm[0] || int'(out_tag) !== q_tag[0]) begin
                  n_fail++; $display("FAIL rnd_data cyc=%0d got %h/%0d want %h/%0d", cycles, out_imm, out_tag, q_imm[0], q_tag[0]);
               end
               void'(q_imm.pop_front()); void'(q_tag.pop_front());
            end
            if (acc) begin
               q_imm.push_back(ext_ref(longint'(in_imm), int'(in_extop), 16, 32)); q_tag.push_back(int'(in_tag));
               beats++;
            end
         end
         cyc(); cycles++;
      end
      flush = 0; in_valid = 0;
      n_chk++; if (beats < 10000) begin n_fail++; $display("FAIL rnd_timeout got %0d beats want 10000", beats); end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_param();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning immediate input width.
REQ-002 The block SHALL have parameter OUT_W, default 32, meaning extended result width; legal range is OUT_W >= IN_W+2.
REQ-003 The block SHALL have parameter TAG_W, default 5, meaning sideband tag width, e.g. a destination register number.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block can accept a beat this cycle.
REQ-009 in_imm  input  IN_W  raw immediate.
REQ-010 in_extop  input  2  mode: 0 zero-ext, 1 sign-ext, 2 upper-load, 3 sign-ext then shift left 2.
REQ-011 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_imm  output  OUT_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of the result beat.

Function
REQ-016 Mode 0 SHALL produce {(OUT_W-IN_W) zeros, imm}.
REQ-017 Mode 1 SHALL produce {(OUT_W-IN_W) copies of imm[IN_W-1], imm}.
REQ-018 Mode 2 SHALL produce {imm, (OUT_W-IN_W) zeros}.
REQ-019 Mode 3 SHALL produce the mode-1 value shifted left by 2, with the upper 2 bits discarded and the low 2 bits zero.
REQ-020 Extension SHALL be computed combinationally on the input side, so only the OUT_W result plus tag is stored.
REQ-021 Storage SHALL be two entries: an output register driving out_* and a skid register.
REQ-022 An input beat SHALL be accepted on a cycle where in_valid=1, in_ready=1 and flush=0.
REQ-023 An output beat SHALL transfer on a cycle where out_valid=1 and out_ready=1.
REQ-024 in_ready SHALL equal NOT skid-valid, which is a registered signal and has no combinational path from out_ready.
REQ-025 The output register loads when it is empty or its beat transfers; it takes the skid entry if the skid is valid, otherwise the accepted input beat, otherwise it goes empty.
REQ-026 When the output register holds a beat, the beat does not transfer, and an input beat is accepted, that input beat SHALL go to the skid register.
REQ-027 When the output register loads from the skid, the skid SHALL be freed.
REQ-028 A beat accepted on that same cycle SHALL then enter the skid; this case cannot occur while in_ready=0.
REQ-029 Latency SHALL be 1 cycle: a beat accepted in cycle N with the output empty appears on out_* in cycle N+1.
REQ-030 Sustained throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-031 While out_valid=1 and out_ready=0, out_imm and out_tag SHALL hold stable.
REQ-032 Beats SHALL leave in acceptance order, with none lost or duplicated.
REQ-033 flush=1 SHALL clear both valid bits at the next edge.
REQ-034 flush SHALL take priority over a simultaneous accept or transfer; the input beat is dropped and in_ready=1 the following cycle.
REQ-035 Data registers need not clear on flush or reset; only valid bits are architecturally visible.

Reset
REQ-036 reset=1 at a rising edge SHALL clear both valid bits, giving out_valid=0 and in_ready=1 from the next cycle.
REQ-037 reset SHALL take priority over flush and all handshakes, including mid-stream with both entries full.
REQ-038 After reset deasserts, the first accepted beat SHALL appear exactly 1 cycle later.

Verification
REQ-039 Modes, defaults, out_ready=1: imm 0x8004 with ops 0/1/2/3 -> 0x00008004, 0xFFFF8004, 0x80040000, 0xFFFE0010; imm 0x7FFF with op 1 -> 0x00007FFF.
REQ-040 Back-pressure: out_ready=0, send tags 1,2,3 -> tags 1,2 accepted, in_ready=0 while tag 3 waits; release out_ready -> tags 1,2,3 out in order on consecutive cycles.
REQ-041 Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped beat never appears.
REQ-042 Reset mid-stream, out_ready=0 with 2 beats held -> out_valid=0, in_ready=1 next cycle; a new beat of imm 0x0001, op 1 emerges 1 cycle after acceptance as 0x00000001.
REQ-043 Parameter sweep IN_W=8, OUT_W=16: imm 0x80 with ops 1/2/3 -> 0xFF80, 0x8000, 0xFE00.
REQ-044 Random valid/ready toggling for 10k beats -> scoreboard matches REQ-016..REQ-019 exactly, with no in_ready to out_ready combinational loop.
